// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          WAIT_W    = 4;

    // Misaligned or beyond the last stored word.
    function automatic logic addr_bad(input logic [31:0] a, input int depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage: synchronous write, registered read, contents never reset.
module imem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder with programmable wait states.
// Optional request statistics counters enabled by IMEM_STATS_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] served_count,
    output logic [31:0] stall_count
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              rd_en;
    logic [AW-1:0]     rd_idx;
    logic [31:0]       rd_data;
    logic              wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rd_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the read launches before addr_q is loaded.
    assign rd_idx = (state_q == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign wr_en  = load_en && !addr_bad(load_addr, DEPTH_WORDS);

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .we_i   (wr_en),
        .waddr_i(load_addr[AW+1:2]),
        .wdata_i(load_data),
        .re_i   (rd_en),
        .raddr_i(rd_idx),
        .rdata_o(rd_data)
    );

    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && addr_bad(addr_q, DEPTH_WORDS);
    assign rsp_instr = !rsp_valid ? 32'h0 :
                       rsp_err    ? NOP_INSTR : rd_data;

`ifdef IMEM_STATS_EN
    logic [31:0] served_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_q <= '0;
            stall_q  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                served_q <= served_q + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign served_count = served_q;
    assign stall_count  = stall_q;
`else
    assign served_count = '0;
    assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: two instances (1 and 3 wait states)
// share stimulus and are checked every cycle against a timestamp model.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = 256;
`ifdef IMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [1:0]        rdy, vld, err;
    logic [1:0][31:0]  ins, srv, stl;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
        .rsp_instr(ins[0]), .rsp_err(err[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .served_count(srv[0]), .stall_count(stl[0])
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
        .rsp_instr(ins[1]), .rsp_err(err[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .served_count(srv[1]), .stall_count(stl[1])
    );

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Model: memory image, and per instance a response due at a fixed
    // edge number after acceptance, held until consumed.
    logic [31:0] mmem [DEPTH];
    int          n_edge;
    bit   [1:0]  busy, evld, eerr;
    logic [1:0][31:0] paddr, einstr;
    int          due[2];
    int          esrv[2], estl[2];

    function automatic int waits(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit bad(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 32'(DEPTH));
    endfunction

    always @(posedge clk or posedge reset) begin
        bit wb;
        if (reset) begin
            busy   = '0;
            evld   = '0;
            n_edge = 0;
            for (int k = 0; k < 2; k++) begin
                esrv[k] = 0;
                estl[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wb = busy[k];
                if (evld[k]) begin
                    if (rsp_ready) begin
                        evld[k] = 1'b0;
                        busy[k] = 1'b0;
                        esrv[k]++;
                    end else begin
                        estl[k]++;
                    end
                end else if (!wb && req_valid) begin
                    busy[k]  = 1'b1;
                    paddr[k] = req_addr;
                    due[k]   = n_edge + waits(k);
                end
                if (busy[k] && !evld[k] && n_edge == due[k]) begin
                    evld[k]   = 1'b1;
                    eerr[k]   = bad(paddr[k]);
                    einstr[k] = eerr[k] ? NOP_INSTR : mmem[paddr[k][9:2]];
                end
            end
            if (load_en && !bad(load_addr)) begin
                mmem[load_addr[9:2]] = load_data;
            end
            n_edge++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("req_ready", k, 32'(rdy[k]), 32'(!busy[k] && !reset));
                chk("rsp_valid", k, 32'(vld[k]), 32'(evld[k]));
                chk("rsp_err", k, 32'(err[k]), 32'(evld[k] && eerr[k]));
                chk("rsp_instr", k, ins[k], evld[k] ? einstr[k] : 32'h0);
                chk("served", k, srv[k], STATS ? 32'(esrv[k]) : 32'h0);
                chk("stall", k, stl[k], STATS ? 32'(estl[k]) : 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_both();
        int b;
        b = 0;
        while (vld != 2'b11 && b < 12) begin
            tick();
            b++;
        end
        chk("both_valid", 0, 32'(vld), 32'd3);
    endtask

    task automatic finish_rsp(input int hold);
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #1 started = 1'b1;
        tick(); tick();
        chk("ready_in_reset", 0, 32'(rdy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 0, 32'(rdy), 32'd3);
        tick();

        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00a0_0113);
        load(32'h8, 32'h1111_1111);
        load(32'h400, 32'hdead_beef);
        load(32'h2, 32'hbad0_bad0);

        // Latency, hold-stable and stall counting.
        issue(32'h0);
        chk("lat_wait", 0, 32'(vld[0]), 32'd0);
        tick();
        chk("lat_resp", 0, 32'(vld[0]), 32'd1);
        chk("first_instr", 0, ins[0], 32'h0050_0093);
        chk("first_err", 0, 32'(err[0]), 32'd0);
        wait_both();
        repeat (5) begin
            tick();
            chk("hold_instr", 1, ins[1], 32'h0050_0093);
            chk("hold_ready", 1, 32'(rdy[1]), 32'd0);
        end
        chk("stall_lit", 1, stl[1], STATS ? 32'd5 : 32'd0);
        finish_rsp(0);
        chk("served_lit", 1, srv[1], STATS ? 32'd1 : 32'd0);

        // Error responses.
        issue(32'h6);
        wait_both();
        chk("misalign_err", 1, 32'(err[1]), 32'd1);
        chk("misalign_nop", 1, ins[1], 32'h0000_0013);
        finish_rsp(1);
        issue(32'h400);
        wait_both();
        chk("range_err", 0, 32'(err[0]), 32'd1);
        chk("range_nop", 0, ins[0], 32'h0000_0013);
        finish_rsp(0);

        issue(32'h4);
        wait_both();
        chk("word1", 0, ins[0], 32'h00a0_0113);
        finish_rsp(2);
        issue(32'h0);
        wait_both();
        chk("no_alias", 1, ins[1], 32'h0050_0093);
        finish_rsp(0);

        // Load on the edge after acceptance: 1-wait samples old, 3-wait new.
        issue(32'h8);
        load(32'h8, 32'h2222_2222);
        wait_both();
        chk("rbw_old", 0, ins[0], 32'h1111_1111);
        chk("early_new", 1, ins[1], 32'h2222_2222);
        finish_rsp(0);
        issue(32'h8);
        tick(); tick();
        load(32'h8, 32'h3333_3333);
        wait_both();
        chk("sample_edge_old", 1, ins[1], 32'h2222_2222);
        finish_rsp(0);
        issue(32'h8);
        wait_both();
        chk("after_load", 1, ins[1], 32'h3333_3333);
        finish_rsp(0);

        // Reset while both instances wait.
        issue(32'h0);
        #1 reset = 1'b1;
        #1;
        chk("rst_kill_valid", 0, 32'(vld), 32'd0);
        chk("rst_ready_low", 0, 32'(rdy), 32'd0);
        chk("rst_served", 1, srv[1], 32'd0);
        tick(); tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("no_orphan", 0, 32'(vld), 32'd0);
        chk("ready_back", 0, 32'(rdy), 32'd3);
        issue(32'h0);
        wait_both();
        chk("mem_kept", 1, ins[1], 32'h0050_0093);
        finish_rsp(1);
        chk("served_post_rst", 0, srv[0], STATS ? 32'd1 : 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
